// File: rtl/aes_ctr_frame_builder_pkg.sv
// rtl/aes_ctr_frame_builder_pkg.sv - shared AES constants, FSM state type and popcount helper
package aes_ctr_frame_builder_pkg;

    localparam int BLOCK_SIZE = 128;
    localparam int KEY_LENGTH = 256;
    localparam int KEEP_WIDTH = BLOCK_SIZE / 8;

    // One-hot frame builder states
    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_KEY_LO  = 6'b000010,
        ST_KEY_HI  = 6'b000100,
        ST_COUNTER = 6'b001000,
        ST_GATHER  = 6'b010000,
        ST_EMIT    = 6'b100000
    } state_t;

    // Number of set bits in a byte-enable vector (up to one block of lanes)
    function automatic logic [4:0] popcount(input logic [KEEP_WIDTH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/aes_ctr_frame_builder_if.sv
// rtl/aes_ctr_frame_builder_if.sv - AXI-Stream style bundle with master/slave modports
interface aes_ctr_frame_builder_if #(
    parameter int DATA_WIDTH = 128
);

    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/aes_word_packer.sv
// rtl/aes_word_packer.sv - assembles narrow payload words into one 128-bit text block
module aes_word_packer
    import aes_ctr_frame_builder_pkg::*;
#(
    parameter int IN_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  clear,
    input  logic                  write,
    input  logic [IN_WIDTH-1:0]   data,
    input  logic [IN_WIDTH/8-1:0] keep,
    input  logic                  last_in,
    output logic [BLOCK_SIZE-1:0] block,
    output logic [KEEP_WIDTH-1:0] block_keep,
    output logic                  last,
    output logic                  full
);

    localparam int SLOTS = BLOCK_SIZE / IN_WIDTH;
    localparam int KW    = IN_WIDTH / 8;
    localparam int IDX_W = $clog2(SLOTS);

    logic [IDX_W-1:0] idx;

    // The next write lands in the final slot of the block
    assign full = (idx == IDX_W'(SLOTS - 1));

    // Slot writes; a block closes on tlast or when the last slot is filled
    always_ff @(posedge Clk) begin
        if (Rst || clear) begin
            block      <= '0;
            block_keep <= '0;
            last       <= 1'b0;
            idx        <= '0;
        end else if (write) begin
            block[idx*IN_WIDTH +: IN_WIDTH] <= data;
            block_keep[idx*KW +: KW]        <= keep;
            if (last_in || full) begin
                idx  <= '0;
                last <= last_in;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/aes_ctr_frame_builder.sv
// rtl/aes_ctr_frame_builder.sv - frames payload as key-lo/key-hi/IV headers plus text blocks; option AES_FRAME_BYTE_COUNT_EN
module aes_ctr_frame_builder
    import aes_ctr_frame_builder_pkg::*;
#(
    parameter int IN_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [KEY_LENGTH-1:0] Cfg_key,
    input  logic [BLOCK_SIZE-1:0] Cfg_iv,
    input  logic                  Cfg_encrypt,
`ifdef AES_FRAME_BYTE_COUNT_EN
    output logic [31:0]           Frame_bytes,
    output logic                  Frame_done,
`endif
    aes_ctr_frame_builder_if.slave  S_axis,
    aes_ctr_frame_builder_if.master M_axis
);

    state_t                  state;
    logic [BLOCK_SIZE-1:0]   key_hi_q;
    logic [BLOCK_SIZE-1:0]   iv_q;
    logic [BLOCK_SIZE-1:0]   hdr_data_q;
    logic [KEEP_WIDTH-1:0]   hdr_keep_q;
    logic                    m_tvalid_q;
    logic                    m_tuser_q;
    logic                    s_tready_q;

    logic                    s_accept;
    logic                    m_fire;
    logic                    pk_clear;
    logic                    pk_write;
    logic [BLOCK_SIZE-1:0]   pk_block;
    logic [KEEP_WIDTH-1:0]   pk_keep;
    logic                    pk_last;
    logic                    pk_full;

    assign s_accept = S_axis.tvalid & s_tready_q;
    assign m_fire   = m_tvalid_q & M_axis.tready;
    assign pk_write = (state == ST_GATHER) & s_accept;
    assign pk_clear = (state == ST_EMIT) & m_fire;

    aes_word_packer #(
        .IN_WIDTH (IN_WIDTH)
    ) u_packer (
        .Clk        (Clk),
        .Rst        (Rst),
        .clear      (pk_clear),
        .write      (pk_write),
        .data       (S_axis.tdata),
        .keep       (S_axis.tkeep),
        .last_in    (S_axis.tlast),
        .block      (pk_block),
        .block_keep (pk_keep),
        .last       (pk_last),
        .full       (pk_full)
    );

    // Text blocks come straight from the packer registers, which are frozen while in ST_EMIT
    assign M_axis.tvalid = m_tvalid_q;
    assign M_axis.tdata  = (state == ST_EMIT) ? pk_block : hdr_data_q;
    assign M_axis.tkeep  = (state == ST_EMIT) ? pk_keep  : hdr_keep_q;
    assign M_axis.tlast  = (state == ST_EMIT) & pk_last;
    assign M_axis.tuser  = m_tuser_q;
    assign S_axis.tready = s_tready_q;

    // Frame sequencing: config latch, three header beats, then gather/emit per block
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= ST_IDLE;
            key_hi_q   <= '0;
            iv_q       <= '0;
            hdr_data_q <= '0;
            hdr_keep_q <= '0;
            m_tvalid_q <= 1'b0;
            m_tuser_q  <= 1'b0;
            s_tready_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (S_axis.tvalid) begin
                        key_hi_q   <= Cfg_key[KEY_LENGTH-1:BLOCK_SIZE];
                        iv_q       <= Cfg_iv;
                        m_tuser_q  <= Cfg_encrypt;
                        hdr_data_q <= Cfg_key[BLOCK_SIZE-1:0];
                        hdr_keep_q <= '1;
                        m_tvalid_q <= 1'b1;
                        state      <= ST_KEY_LO;
                    end
                end
                ST_KEY_LO: begin
                    if (m_fire) begin
                        hdr_data_q <= key_hi_q;
                        state      <= ST_KEY_HI;
                    end
                end
                ST_KEY_HI: begin
                    if (m_fire) begin
                        hdr_data_q <= iv_q;
                        state      <= ST_COUNTER;
                    end
                end
                ST_COUNTER: begin
                    if (m_fire) begin
                        m_tvalid_q <= 1'b0;
                        hdr_keep_q <= '0;
                        s_tready_q <= 1'b1;
                        state      <= ST_GATHER;
                    end
                end
                ST_GATHER: begin
                    if (s_accept && (S_axis.tlast || pk_full)) begin
                        s_tready_q <= 1'b0;
                        m_tvalid_q <= 1'b1;
                        state      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (m_fire) begin
                        m_tvalid_q <= 1'b0;
                        if (pk_last) begin
                            state <= ST_IDLE;
                        end else begin
                            s_tready_q <= 1'b1;
                            state      <= ST_GATHER;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    m_tvalid_q <= 1'b0;
                    s_tready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_FRAME_BYTE_COUNT_EN
    assign Frame_done = pk_clear & pk_last;

    // Payload byte tally, restarted whenever a new frame leaves ST_IDLE
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Frame_bytes <= '0;
        end else if ((state == ST_IDLE) && S_axis.tvalid) begin
            Frame_bytes <= '0;
        end else if (s_accept) begin
            Frame_bytes <= Frame_bytes + 32'(popcount(KEEP_WIDTH'(S_axis.tkeep)));
        end
    end
`endif

endmodule

// File: tb/tb_aes_ctr_frame_builder.sv
// tb/tb_aes_ctr_frame_builder.sv - randomized self-checking bench with byte-level frame model
module tb_aes_ctr_frame_builder;
    import aes_ctr_frame_builder_pkg::*;

    localparam int IN_WIDTH = 32;
    localparam int KW       = IN_WIDTH / 8;

    typedef logic [7:0] bytes_t[$];

    logic         Clk = 1'b0;
    logic         Rst;
    logic [255:0] Cfg_key;
    logic [127:0] Cfg_iv;
    logic         Cfg_encrypt;
`ifdef AES_FRAME_BYTE_COUNT_EN
    logic [31:0]  Frame_bytes;
    logic         Frame_done;
`endif

    aes_ctr_frame_builder_if #(.DATA_WIDTH(IN_WIDTH)) s_if ();
    aes_ctr_frame_builder_if #(.DATA_WIDTH(128))      m_if ();

    aes_ctr_frame_builder #(.IN_WIDTH(IN_WIDTH)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Cfg_key     (Cfg_key),
        .Cfg_iv      (Cfg_iv),
        .Cfg_encrypt (Cfg_encrypt),
`ifdef AES_FRAME_BYTE_COUNT_EN
        .Frame_bytes (Frame_bytes),
        .Frame_done  (Frame_done),
`endif
        .S_axis      (s_if),
        .M_axis      (m_if)
    );

    always #5 Clk = ~Clk;

    logic [127:0] exp_data[$];
    logic [15:0]  exp_keep[$];
    logic         exp_last[$];
    logic         exp_user[$];
    int           exp_bytes[$];
    int           n_vec = 0;
    int           n_err = 0;
    bit           stall_en = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] swap256(input logic [255:0] h);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = h[255-8*i -: 8];
        return r;
    endfunction

    function automatic logic [127:0] swap128(input logic [127:0] h);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = h[127-8*i -: 8];
        return r;
    endfunction

    // Expected frame: three header beats, then payload bytes cut into 16-byte blocks
    task automatic model_frame(input logic [255:0] key, input logic [127:0] iv, input logic enc,
                               input bytes_t pl, input bit hdr_only);
        int nblk;
        exp_data.push_back(key[127:0]);   exp_keep.push_back(16'hFFFF); exp_last.push_back(1'b0); exp_user.push_back(enc);
        exp_data.push_back(key[255:128]); exp_keep.push_back(16'hFFFF); exp_last.push_back(1'b0); exp_user.push_back(enc);
        exp_data.push_back(iv);           exp_keep.push_back(16'hFFFF); exp_last.push_back(1'b0); exp_user.push_back(enc);
        if (!hdr_only) begin
            nblk = (pl.size() + 15) / 16;
            if (nblk == 0) nblk = 1;
            for (int b = 0; b < nblk; b++) begin
                logic [127:0] d;
                logic [15:0]  k;
                d = '0;
                k = '0;
                for (int i = 0; i < 16; i++) begin
                    if (16*b + i < pl.size()) begin
                        d[8*i +: 8] = pl[16*b + i];
                        k[i] = 1'b1;
                    end
                end
                exp_data.push_back(d); exp_keep.push_back(k);
                exp_last.push_back(b == nblk - 1); exp_user.push_back(enc);
            end
            exp_bytes.push_back(pl.size());
        end
    endtask

    task automatic new_cfg();
        for (int i = 0; i < 8; i++) Cfg_key[32*i +: 32] = $urandom;
        for (int i = 0; i < 4; i++) Cfg_iv[32*i +: 32] = $urandom;
        Cfg_encrypt = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        do begin
            @(negedge Clk);
            t++;
        end while (exp_data.size() != 0 && t < 3000);
        if (exp_data.size() != 0) begin
            check("drain_timeout", 128'(exp_data.size()), 128'(0));
            exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_user.delete(); exp_bytes.delete();
        end
        @(posedge Clk); #1;
        check("idle_tvalid", 128'(m_if.tvalid), 128'(0));
        check("idle_tready", 128'(s_if.tready), 128'(0));
    endtask

    // Drive one packet; rst_after > 0 pulses Rst once that many words are accepted
    task automatic send_packet(input bytes_t pl, input int rst_after);
        int nw;
        int t;
        wait_drain();
        nw = (pl.size() + KW - 1) / KW;
        if (nw == 0) nw = 1;
        model_frame(Cfg_key, Cfg_iv, Cfg_encrypt, pl, rst_after > 0);
        for (int w = 0; w < nw; w++) begin
            logic [IN_WIDTH-1:0] d;
            logic [KW-1:0]       k;
            d = '0;
            k = '0;
            for (int j = 0; j < KW; j++) begin
                if (w*KW + j < pl.size()) begin
                    d[8*j +: 8] = pl[w*KW + j];
                    k[j] = 1'b1;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                s_if.tvalid = 1'b0;
                @(posedge Clk); #1;
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = d;
            s_if.tkeep  = k;
            s_if.tlast  = (w == nw - 1);
            if (w == 0) begin
                @(posedge Clk); #1;
                new_cfg();
            end
            t = 0;
            do begin
                @(negedge Clk);
                t++;
            end while (!s_if.tready && t < 300);
            if (!s_if.tready) begin
                check("accept_timeout", 128'(0), 128'(1));
                s_if.tvalid = 1'b0;
                return;
            end
            @(posedge Clk); #1;
            if (w + 1 == rst_after) begin
                Rst = 1'b1;
                s_if.tvalid = 1'b0;
                s_if.tlast  = 1'b0;
                @(negedge Clk);
                check("rst_mid_tvalid", 128'(m_if.tvalid), 128'(0));
                @(posedge Clk); #1;
                Rst = 1'b0;
                @(negedge Clk);
                check("post_rst_tvalid", 128'(m_if.tvalid), 128'(0));
                check("post_rst_tready", 128'(s_if.tready), 128'(0));
                return;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    function automatic bytes_t rand_bytes(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    // Downstream ready: always 1, or a coin flip each cycle while stalls are enabled
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge Clk); #1;
            m_if.tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: beat-by-beat compare plus hold-while-stalled check
    initial begin : monitor
        logic         stalled;
        logic [127:0] hd;
        logic [15:0]  hk;
        logic [127:0] ed;
        logic [15:0]  ek;
        logic         el;
        logic         eu;
        stalled = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_tvalid", 128'(m_if.tvalid), 128'(1));
                    check("hold_tdata", m_if.tdata, hd);
                    check("hold_tkeep", 128'(m_if.tkeep), 128'(hk));
                end
                stalled = m_if.tvalid && !m_if.tready;
                hd = m_if.tdata;
                hk = m_if.tkeep;
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_data.size() == 0) begin
                        check("extra_beat", 128'(1), 128'(0));
                    end else begin
                        ed = exp_data.pop_front();
                        ek = exp_keep.pop_front();
                        el = exp_last.pop_front();
                        eu = exp_user.pop_front();
                        check("beat_tdata", m_if.tdata, ed);
                        check("beat_tkeep", 128'(m_if.tkeep), 128'(ek));
                        check("beat_tlast", 128'(m_if.tlast), 128'(el));
                        check("beat_tuser", 128'(m_if.tuser), 128'(eu));
`ifdef AES_FRAME_BYTE_COUNT_EN
                        check("frame_done", 128'(Frame_done), 128'(el));
                        if (el && exp_bytes.size() != 0)
                            check("frame_bytes", 128'(Frame_bytes), 128'(exp_bytes.pop_front()));
`endif
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [255:0] nist_key;
        logic [127:0] nist_iv;
        logic [511:0] nist_pt;
        bytes_t       pl;

        Rst         = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        Cfg_key     = '0;
        Cfg_iv      = '0;
        Cfg_encrypt = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_m_tvalid", 128'(m_if.tvalid), 128'(0));
        check("rst_m_tdata", m_if.tdata, 128'(0));
        check("rst_m_tkeep", 128'(m_if.tkeep), 128'(0));
        check("rst_m_tlast", 128'(m_if.tlast), 128'(0));
        check("rst_m_tuser", 128'(m_if.tuser), 128'(0));
        check("rst_s_tready", 128'(s_if.tready), 128'(0));
        @(posedge Clk); #1;
        Rst = 1'b0;

        // NIST SP800-38A CTR-AES256 vector, byte 0 of each field in bits [7:0]
        nist_key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        nist_iv  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        nist_pt  = {128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                    128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
        Cfg_key     = swap256(nist_key);
        Cfg_iv      = swap128(nist_iv);
        Cfg_encrypt = 1'b1;
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(nist_pt[511-8*i -: 8]);
        send_packet(pl, 0);

        // Short and boundary lengths under downstream stalls
        stall_en = 1'b1;
        send_packet(rand_bytes(22), 0);
        send_packet(rand_bytes(20), 0);
        send_packet(rand_bytes(0), 0);
        send_packet(rand_bytes(16), 0);
        send_packet(rand_bytes(17), 0);

        // Reset with two words held in the packer, then a clean packet
        send_packet(rand_bytes(40), 2);
        send_packet(rand_bytes(32), 0);

        for (int p = 0; p < 30; p++) begin
            stall_en = 1'($urandom_range(0, 1));
            send_packet(rand_bytes(int'($urandom_range(0, 80))), 0);
        end
        stall_en = 1'b1;
        wait_drain();
        repeat (4) @(posedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
